// File: rtl/whack_a_mole_gen_pkg.sv
// Shared types and constants for the whack-a-mole core.
package whack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      ACTIVE,
      GAP,
      OVER
   } state_t;

   // Segment glyphs, bit order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_E    = 7'h79;

   // Galois LFSR for x^16+x^14+x^13+x^11+1 in right-shift form.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'h3F;
         4'd1:    g = 7'h06;
         4'd2:    g = 7'h5B;
         4'd3:    g = 7'h4F;
         4'd4:    g = 7'h66;
         4'd5:    g = 7'h6D;
         4'd6:    g = 7'h7D;
         4'd7:    g = 7'h07;
         4'd8:    g = 7'h7F;
         4'd9:    g = 7'h6F;
         default: g = SEG_DASH;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/whack_a_mole_gen_if.sv
// Board-side bundle: buttons/control in, LEDs/score/display out.
interface whack_a_mole_gen_if #(
   parameter int NUM_MOLES = 8,
   parameter int SCORE_W   = 8
);
   logic [NUM_MOLES-1:0] btn;
   logic                 start;
   logic                 game_end;
   logic [NUM_MOLES-1:0] mole;
   logic [SCORE_W-1:0]   score;
   logic [3:0]           lives;
   logic [3:0]           level;
   logic [6:0]           seg;
   logic                 dp;
   logic                 game_over;

   modport master (
      output btn, start, game_end,
      input  mole, score, lives, level, seg, dp, game_over
   );

   modport slave (
      input  btn, start, game_end,
      output mole, score, lives, level, seg, dp, game_over
   );
endinterface

// File: rtl/whack_a_mole_gen_lfsr.sv
// Free-running 16-bit Galois LFSR used for mole selection.
module mole_lfsr
   import whack_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr
);

   // Shift right every clock; feed the dropped bit back through the taps.
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
   end

endmodule

// File: rtl/whack_a_mole_gen.sv
// Whack-a-mole game core: input conditioning, tick prescaler, game FSM, display.
//
// state  | meaning
// IDLE   | waiting for first start edge, display dash
// SPAWN  | one cycle: pick mole index, load window
// ACTIVE | mole lit, waiting for hit / miss / timeout
// GAP    | blank between moles, buttons ignored
// OVER   | game finished, display 'E', wait for start
module whack_a_mole_gen
   import whack_pkg::*;
#(
   parameter int NUM_MOLES      = 8,
   parameter int SCORE_W        = 8,
   parameter int LIVES          = 3,
   parameter int TICK_DIV       = 50000,
   parameter int WINDOW_BASE    = 40,
   parameter int WINDOW_STEP    = 4,
   parameter int WINDOW_MIN     = 8,
   parameter int GAP_TICKS      = 10,
   parameter int HITS_PER_LEVEL = 5,
   parameter int MAX_LEVEL      = 9
)(
   input logic               clk,
   input logic               rst,
   whack_a_mole_gen_if.slave bus
);

   localparam int IW = $clog2(NUM_MOLES);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [NUM_MOLES-1:0] btn_s1, btn_s2, btn_s3, btn_edge;
   logic                 start_s1, start_s2, start_s3, start_edge;
   logic [PW-1:0]        presc;
   logic                 tick;
   logic [15:0]          lfsr;
   logic [31:0]          lfsr_ext;

   state_t               state, state_n;
   logic [SCORE_W-1:0]   score, score_n;
   logic [3:0]           lives, lives_n, level, level_n;
   logic [7:0]           hit_cnt, hit_cnt_n;
   logic [15:0]          win_cnt, win_cnt_n, gap_cnt, gap_cnt_n, win_len;
   logic [IW-1:0]        idx, idx_n, rnd_idx, spawn_idx;
   logic                 dp, dp_n;
   logic [NUM_MOLES-1:0] mole_bit;
   int                   win_tmp;

   mole_lfsr u_lfsr (.clk(clk), .rst(rst), .lfsr(lfsr));

   // Two-flop synchronisers plus a history flop for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1   <= '0; btn_s2   <= '0; btn_s3   <= '0;
         start_s1 <= 1'b0; start_s2 <= 1'b0; start_s3 <= 1'b0;
      end else begin
         btn_s1   <= bus.btn;   btn_s2   <= btn_s1;   btn_s3   <= btn_s2;
         start_s1 <= bus.start; start_s2 <= start_s1; start_s3 <= start_s2;
      end
   end

   assign btn_edge   = btn_s2 & ~btn_s3;
   assign start_edge = start_s2 & ~start_s3;

   // Free-running game tick prescaler.
   always_ff @(posedge clk) begin
      if (rst || tick) presc <= '0;
      else             presc <= presc + PW'(1);
   end

   assign tick = (presc == PW'(TICK_DIV - 1));

   // Next mole index, bumped by one when the LFSR repeats the previous mole.
   assign lfsr_ext  = {16'd0, lfsr};
   assign rnd_idx   = IW'(lfsr_ext % 32'(NUM_MOLES));
   assign spawn_idx = (rnd_idx != idx) ? rnd_idx :
                      (rnd_idx == IW'(NUM_MOLES - 1)) ? '0 : rnd_idx + IW'(1);
   assign mole_bit  = NUM_MOLES'(1) << idx;

   // Window length for the current level, floored at the minimum.
   always_comb begin
      win_tmp = WINDOW_BASE - int'(level) * WINDOW_STEP;
      if (win_tmp < WINDOW_MIN) win_tmp = WINDOW_MIN;
      win_len = 16'(win_tmp);
   end

   // FSM state and game counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         score   <= '0;
         lives   <= 4'(LIVES);
         level   <= '0;
         hit_cnt <= '0;
         win_cnt <= '0;
         gap_cnt <= '0;
         idx     <= '0;
         dp      <= 1'b0;
      end else begin
         state   <= state_n;
         score   <= score_n;
         lives   <= lives_n;
         level   <= level_n;
         hit_cnt <= hit_cnt_n;
         win_cnt <= win_cnt_n;
         gap_cnt <= gap_cnt_n;
         idx     <= idx_n;
         dp      <= dp_n;
      end
   end

   // Next-state and counter updates; game_end pre-empts any same-cycle outcome.
   always_comb begin
      state_n   = state;
      score_n   = score;
      lives_n   = lives;
      level_n   = level;
      hit_cnt_n = hit_cnt;
      win_cnt_n = win_cnt;
      gap_cnt_n = gap_cnt;
      idx_n     = idx;
      dp_n      = dp;
      case (state)
         IDLE, OVER: begin
            if (start_edge) begin
               score_n   = '0;
               lives_n   = 4'(LIVES);
               level_n   = '0;
               hit_cnt_n = '0;
               dp_n      = 1'b0;
               state_n   = SPAWN;
            end
         end
         SPAWN: begin
            if (bus.game_end) begin
               state_n = OVER;
            end else begin
               idx_n     = spawn_idx;
               win_cnt_n = win_len;
               state_n   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.game_end) begin
               state_n = OVER;
            end else if (btn_edge == mole_bit) begin
               score_n   = (score == '1) ? score : score + SCORE_W'(1);
               dp_n      = 1'b1;
               gap_cnt_n = 16'(GAP_TICKS);
               state_n   = GAP;
               if (hit_cnt + 8'd1 == 8'(HITS_PER_LEVEL)) begin
                  hit_cnt_n = '0;
                  if (level != 4'(MAX_LEVEL)) level_n = level + 4'd1;
               end else begin
                  hit_cnt_n = hit_cnt + 8'd1;
               end
            end else if ((btn_edge != '0) || (tick && win_cnt <= 16'd1)) begin
               lives_n   = lives - 4'd1;
               dp_n      = 1'b0;
               gap_cnt_n = 16'(GAP_TICKS);
               state_n   = (lives == 4'd1) ? OVER : GAP;
            end else if (tick) begin
               win_cnt_n = win_cnt - 16'd1;
            end
         end
         GAP: begin
            if (bus.game_end) begin
               state_n = OVER;
            end else if (tick) begin
               if (gap_cnt <= 16'd1) begin
                  dp_n    = 1'b0;
                  state_n = SPAWN;
               end else begin
                  gap_cnt_n = gap_cnt - 16'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.mole      = (state == ACTIVE) ? mole_bit : '0;
   assign bus.seg       = (state == IDLE) ? SEG_DASH :
                          (state == OVER) ? SEG_E : seg_digit(level);
   assign bus.game_over = (state == OVER);
   assign bus.score     = score;
   assign bus.lives     = lives;
   assign bus.level     = level;
   assign bus.dp        = dp;

endmodule

// File: doc/whack_a_mole_gen.md
Name: whack_a_mole_gen

Overview:
- Parametrised next-generation whack-a-mole core: N moles, configurable lives, difficulty levels that shrink the mole window, and explicit start/game-over control.
- Sits between the board buttons/LEDs and the 7-segment display.
- Drives a one-hot mole LED bus, a saturating score and lives count, and a 7-segment status digit.
- Pseudo-random mole selection comes from an internal LFSR sub-module.

Parameters:
- NUM_MOLES, 8, number of buttons/mole LEDs (2..16).
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1.
- LIVES, 3, lives at game start (1..15).
- TICK_DIV, 50000, clocks per game tick (1 allowed for simulation).
- WINDOW_BASE, 40, mole-visible ticks at level 0.
- WINDOW_STEP, 4, ticks removed per level.
- WINDOW_MIN, 8, floor on the window.
- GAP_TICKS, 10, blank ticks between moles.
- HITS_PER_LEVEL, 5, hits needed to advance a level.
- MAX_LEVEL, 9, level ceiling (<=15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn  in  NUM_MOLES  raw buttons, active-high, asynchronous to clk.
- start  in  1  start/restart request; rising edge acts.
- game_end  in  1  external abort; level-sensitive.
- mole  out  NUM_MOLES  one-hot active mole, 0 when none.
- score  out  SCORE_W  current score.
- lives  out  4  remaining lives.
- level  out  4  current level.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp  out  1  hit indicator.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset values:
  - State IDLE; mole=0, score=0, lives=LIVES, level=0.
  - seg=dash (only g lit); dp=0, game_over=0.
  - LFSR=16'hACE1; tick prescaler=0.
- Input conditioning:
  - btn and start each pass through a 2-flop synchroniser, then rising-edge detect.
  - Press edge is visible 3 cycles after the raw input rises; a held button counts once.
- Tick: prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at wrap. It is free-running.
- LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1, advances every clock in all states.
- IDLE:
  - mole=0, seg=dash.
  - start edge: score=0, lives=LIVES, level=0, hit counter=0, then go to SPAWN.
- SPAWN (1 cycle):
  - idx = lfsr mod NUM_MOLES; if idx equals the previous mole, idx=(idx+1) mod NUM_MOLES.
  - Window counter = max(WINDOW_BASE - level*WINDOW_STEP, WINDOW_MIN).
  - Next state ACTIVE.
- ACTIVE:
  - mole=1<<idx. Window counter decrements on each tick.
  - Evaluate each cycle:
    - Hit: edge vector equals exactly the mole bit. score+1 (saturating), dp=1, hit counter+1.
      - If the hit counter reaches HITS_PER_LEVEL: clear it, and level+1 unless level==MAX_LEVEL.
    - Miss: any edge vector that is nonzero and not exactly the mole bit (wrong or multiple buttons). lives-1.
    - Timeout: window reaches 0 on a tick. lives-1.
  - Outcome handling:
    - Any outcome clears mole on the next cycle.
    - Go to OVER if lives becomes 0, else GAP with gap counter = GAP_TICKS.
  - Hit and timeout in the same cycle: hit wins.
- GAP:
  - mole=0; button edges are ignored.
  - dp holds its value from the last outcome.
  - Gap counter decrements per tick; at 0, clear dp and go to SPAWN.
- OVER:
  - game_over=1, mole=0; seg shows 'E'. score/level/lives hold.
  - start edge behaves as from IDLE.
- game_end=1 in SPAWN/ACTIVE/GAP: next state OVER. It beats a same-cycle hit or miss, with no score or lives change. It is ignored in IDLE and OVER.
- seg in SPAWN/ACTIVE/GAP: hex digit of level (0-9 glyphs).
- start edge while playing is ignored.
- rst mid-game restores all reset values on the next edge.

Decomposition:
- Package whack_pkg:
  - state enum: IDLE, SPAWN, ACTIVE, GAP, OVER.
  - 7-segment glyph constants: 0-9, dash, E.
  - LFSR seed and tap constants.
- Sub-module mole_lfsr: 16-bit Galois LFSR with rst/seed, free-running, exposes the state.
- Top holds: synchronisers, edge detect, prescaler, FSM, counters, seg decode.

Test Plan (TICK_DIV=1, WINDOW_BASE=6, WINDOW_STEP=2, WINDOW_MIN=2, GAP_TICKS=2, HITS_PER_LEVEL=2, LIVES=3):
1. Reset, then start pulse -> SPAWN after 3 cycles, ACTIVE the next; mole one-hot; seg=level-0 glyph; lives=3, score=0.
2. Press exactly the mole button -> score=1, dp=1, mole=0 next cycle; a second hit gives score=2, level=1, and the next window is 4 ticks.
3. Press a wrong button, or two buttons with the mole bit included -> lives decrements, score unchanged, dp=0.
4. No press for 6 ticks -> timeout; after 3 timeouts game_over=1, seg='E', mole=0; start edge -> lives=3, score=0.
5. Assert game_end in the same cycle as a correct press -> OVER, score unchanged; rst mid-ACTIVE -> all outputs at reset values.
6. Over 50 spawns, the mole index never equals the previous index; hold a button 20 cycles -> exactly one hit counted.
